// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and EX-stage
// forwarding select generation.
module id_ex_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic [3:0]        id_src1,
  input  logic [3:0]        id_src2,
  input  logic [3:0]        id_dest,
  input  logic [3:0]        id_exe_cmd,
  input  logic [11:0]       id_shift_op,
  input  logic              id_valid,
  input  logic              id_two_src,
  input  logic              id_imm,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mem_w_en,
  input  logic              id_b,
  input  logic              id_s,
  input  logic              freeze,
  input  logic              flush,
  input  logic              forward_en,
  input  logic [3:0]        mem_dest,
  input  logic [3:0]        wb_dest,
  input  logic              mem_wb_en,
  input  logic              wb_wb_en,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_exe_cmd,
  output logic [11:0]       ex_shift_op,
  output logic              ex_valid,
  output logic              ex_two_src,
  output logic              ex_imm,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic              hazard
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [3:0]        dest;
    logic [3:0]        exe_cmd;
    logic [11:0]       shift_op;
    logic              valid;
    logic              two_src;
    logic              imm;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
  } stage_t;

  stage_t id_d;
  stage_t ex_q;
  logic   ex_hit;
  logic   mem_hit;
  logic   load_use;
  logic   no_fwd_dep;

  assign id_d = {id_pc, id_val_rn, id_val_rm, id_src1, id_src2, id_dest,
                 id_exe_cmd, id_shift_op, id_valid, id_two_src, id_imm,
                 id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s};

  // Stage register: reset/flush/bubble all clear, freeze holds, else load.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || (!freeze && hazard)) begin
      ex_q <= '0;
    end else if (!freeze) begin
      ex_q <= id_d;
    end
  end

  // ID sources against EX and MEM destinations.
  always_comb begin
    ex_hit     = (id_src1 == ex_q.dest) | (id_two_src & (id_src2 == ex_q.dest));
    mem_hit    = (id_src1 == mem_dest)  | (id_two_src & (id_src2 == mem_dest));
    load_use   = ex_q.valid & ex_q.mem_r_en & ex_hit;
    no_fwd_dep = ~forward_en & ((ex_q.valid & ex_q.wb_en & ex_hit) | (mem_wb_en & mem_hit));
    hazard     = id_valid & (load_use | no_fwd_dep);
  end

  // Forwarding selects; MEM result takes priority over WB result.
  always_comb begin
    sel_src1 = 2'd0;
    sel_src2 = 2'd0;
    if (ex_q.valid && forward_en) begin
      if (mem_wb_en && (mem_dest == ex_q.src1)) begin
        sel_src1 = 2'd1;
      end else if (wb_wb_en && (wb_dest == ex_q.src1)) begin
        sel_src1 = 2'd2;
      end
      if (ex_q.two_src) begin
        if (mem_wb_en && (mem_dest == ex_q.src2)) begin
          sel_src2 = 2'd1;
        end else if (wb_wb_en && (wb_dest == ex_q.src2)) begin
          sel_src2 = 2'd2;
        end
      end
    end
  end

  assign ex_pc       = ex_q.pc;
  assign ex_val_rn   = ex_q.val_rn;
  assign ex_val_rm   = ex_q.val_rm;
  assign ex_src1     = ex_q.src1;
  assign ex_src2     = ex_q.src2;
  assign ex_dest     = ex_q.dest;
  assign ex_exe_cmd  = ex_q.exe_cmd;
  assign ex_shift_op = ex_q.shift_op;
  assign ex_valid    = ex_q.valid;
  assign ex_two_src  = ex_q.two_src;
  assign ex_imm      = ex_q.imm;
  assign ex_wb_en    = ex_q.wb_en;
  assign ex_mem_r_en = ex_q.mem_r_en;
  assign ex_mem_w_en = ex_q.mem_w_en;
  assign ex_b        = ex_q.b;
  assign ex_s        = ex_q.s;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized
// traffic against a transaction-level model of the stage.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [3:0]  cmd;
    logic [11:0] shop;
    logic        valid;
    logic        two_src;
    logic        imm;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
  } stage_t;

  logic       clk = 1'b0;
  logic       rst_n;
  stage_t     idv;
  logic       freeze, flush, fwd;
  logic [3:0] mem_dest, wb_dest;
  logic       mem_wb_en, wb_wb_en;

  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [3:0]  ex_src1, ex_src2, ex_dest, ex_exe_cmd;
  logic [11:0] ex_shift_op;
  logic        ex_valid, ex_two_src, ex_imm, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
  logic [1:0]  sel_src1, sel_src2;
  logic        hazard;
  stage_t      obs;

  stage_t exp;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_pc(idv.pc), .id_val_rn(idv.rn), .id_val_rm(idv.rm),
    .id_src1(idv.src1), .id_src2(idv.src2), .id_dest(idv.dest),
    .id_exe_cmd(idv.cmd), .id_shift_op(idv.shop),
    .id_valid(idv.valid), .id_two_src(idv.two_src), .id_imm(idv.imm),
    .id_wb_en(idv.wb), .id_mem_r_en(idv.mr), .id_mem_w_en(idv.mw),
    .id_b(idv.b), .id_s(idv.s),
    .freeze(freeze), .flush(flush), .forward_en(fwd),
    .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_exe_cmd(ex_exe_cmd), .ex_shift_op(ex_shift_op),
    .ex_valid(ex_valid), .ex_two_src(ex_two_src), .ex_imm(ex_imm),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_b(ex_b), .ex_s(ex_s),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .hazard(hazard)
  );

  assign obs = {ex_pc, ex_val_rn, ex_val_rm, ex_src1, ex_src2, ex_dest, ex_exe_cmd,
                ex_shift_op, ex_valid, ex_two_src, ex_imm, ex_wb_en, ex_mem_r_en,
                ex_mem_w_en, ex_b, ex_s};

  // Does the ID instruction read register r?
  function automatic logic reads(input logic [3:0] r);
    return (idv.src1 == r) || (idv.two_src && idv.src2 == r);
  endfunction

  function automatic logic m_hazard();
    logic dep_ex;
    if (!idv.valid) return 1'b0;
    dep_ex = exp.valid && reads(exp.dest);
    if (dep_ex && exp.mr) return 1'b1;
    if (!fwd && ((dep_ex && exp.wb) || (mem_wb_en && reads(mem_dest)))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_sel(input logic used, input logic [3:0] r);
    if (!used || !exp.valid || !fwd) return 2'd0;
    if (mem_wb_en && mem_dest == r) return 2'd1;
    if (wb_wb_en && wb_dest == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic stage_t rnd_stage();
    stage_t t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    t.src1 = 4'($urandom_range(0, 3));
    t.src2 = 4'($urandom_range(0, 3));
    t.dest = 4'($urandom_range(0, 3));
    return t;
  endfunction

  // Advance one clock, moving the model along with the DUT.
  task automatic step();
    stage_t nxt;
    if (!rst_n || flush)  nxt = '0;
    else if (freeze)      nxt = exp;
    else if (m_hazard())  nxt = '0;
    else                  nxt = idv;
    @(posedge clk);
    #1;
    exp = nxt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idv = rnd_stage(); idv.valid = 1'b1;
    freeze = 1'b0; flush = 1'b0; fwd = 1'b1;
    mem_dest = 4'd0; wb_dest = 4'd0; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
    exp = '0;
    step(); step();
    checks++; if (obs !== 132'd0) begin failures++; $display("FAIL reset_state got=%h exp=0", obs); end
    checks++; if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", sel_src1, sel_src2); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    rst_n = 1'b1; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
  endtask

  task automatic test_load();
    idv = '0; idv.valid = 1'b1; idv.pc = 32'h10; idv.dest = 4'd3; idv.wb = 1'b1;
    step();
    checks++; if (ex_pc !== 32'h10 || ex_dest !== 4'd3 || ex_wb_en !== 1'b1 || ex_valid !== 1'b1) begin
      failures++; $display("FAIL load_path got pc=%h dest=%0d wb=%b v=%b exp pc=10 dest=3 wb=1 v=1", ex_pc, ex_dest, ex_wb_en, ex_valid);
    end
    checks++; if (obs !== exp) begin failures++; $display("FAIL load_all got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_forwarding();
    idv = '0; idv.valid = 1'b1; idv.src1 = 4'd5; idv.src2 = 4'd5; fwd = 1'b1;
    step();
    mem_dest = 4'd5; wb_dest = 4'd5; mem_wb_en = 1'b1; wb_wb_en = 1'b1; #1;
    checks++; if (sel_src1 !== 2'd1) begin failures++; $display("FAIL fwd_mem got=%0d exp=1", sel_src1); end
    checks++; if (sel_src2 !== 2'd0) begin failures++; $display("FAIL fwd_one_src got=%0d exp=0", sel_src2); end
    mem_wb_en = 1'b0; #1;
    checks++; if (sel_src1 !== 2'd2) begin failures++; $display("FAIL fwd_wb got=%0d exp=2", sel_src1); end
    fwd = 1'b0; #1;
    checks++; if (sel_src1 !== 2'd0) begin failures++; $display("FAIL fwd_off got=%0d exp=0", sel_src1); end
    fwd = 1'b1; wb_wb_en = 1'b0;
  endtask

  task automatic test_load_use();
    idv = '0; idv.valid = 1'b1; idv.mr = 1'b1; idv.wb = 1'b1; idv.dest = 4'd4;
    step();
    idv = '0; idv.valid = 1'b1; idv.src1 = 4'd9; idv.src2 = 4'd4; idv.two_src = 1'b1; idv.wb = 1'b1; #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL load_use_hit got=%b exp=1", hazard); end
    idv.two_src = 1'b0; #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL load_use_one_src got=%b exp=0", hazard); end
    idv.two_src = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0) begin failures++; $display("FAIL bubble got v=%b wb=%b exp 0 0", ex_valid, ex_wb_en); end
    checks++; if (obs !== exp) begin failures++; $display("FAIL bubble_all got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_priority();
    idv = '0; idv.valid = 1'b1; idv.mr = 1'b1; idv.dest = 4'd4; idv.pc = 32'h77;
    step();
    idv = '0; idv.valid = 1'b1; idv.src1 = 4'd4; idv.pc = 32'h99;
    freeze = 1'b1; flush = 1'b1; #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL prio_hazard got=%b exp=1", hazard); end
    step();
    checks++; if (obs !== 132'd0) begin failures++; $display("FAIL flush_prio got=%h exp=0", obs); end
    flush = 1'b0; freeze = 1'b0;
    idv = '0; idv.valid = 1'b1; idv.pc = 32'h10;
    step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idv = rnd_stage(); idv.pc = 32'h2000 + 32'(i);
      step();
      checks++; if (ex_pc !== 32'h10) begin failures++; $display("FAIL freeze_hold[%0d] got=%h exp=10", i, ex_pc); end
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset_mid();
    idv = '0; idv.valid = 1'b1; idv.wb = 1'b1; idv.dest = 4'd7; idv.src1 = 4'd2;
    step();
    idv = rnd_stage(); idv.valid = 1'b1; idv.src1 = 4'd7;
    freeze = 1'b1; rst_n = 1'b0;
    step();
    checks++; if (obs !== 132'd0) begin failures++; $display("FAIL reset_mid got=%h exp=0", obs); end
    checks++; if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0 || hazard !== 1'b0) begin
      failures++; $display("FAIL reset_mid_comb got=%0d/%0d/%b exp=0/0/0", sel_src1, sel_src2, hazard);
    end
    rst_n = 1'b1; freeze = 1'b0;
    idv = rnd_stage(); idv.valid = 1'b1; idv.pc = 32'hABCD;
    step();
    checks++; if (ex_pc !== 32'hABCD || ex_valid !== 1'b1) begin failures++; $display("FAIL reset_resume got pc=%h v=%b exp pc=abcd v=1", ex_pc, ex_valid); end
    checks++; if (obs !== exp) begin failures++; $display("FAIL reset_resume_all got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idv       = rnd_stage();
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 39) != 0);
      fwd       = ($urandom_range(0, 3) != 0);
      mem_dest  = 4'($urandom_range(0, 3));
      wb_dest   = 4'($urandom_range(0, 3));
      mem_wb_en = 1'($urandom);
      wb_wb_en  = 1'($urandom);
      #1;
      checks++; if (hazard !== m_hazard()) begin failures++; $display("FAIL rnd_hazard[%0d] got=%b exp=%b", i, hazard, m_hazard()); end
      checks++; if (sel_src1 !== m_sel(1'b1, exp.src1)) begin failures++; $display("FAIL rnd_sel1[%0d] got=%0d exp=%0d", i, sel_src1, m_sel(1'b1, exp.src1)); end
      checks++; if (sel_src2 !== m_sel(exp.two_src, exp.src2)) begin failures++; $display("FAIL rnd_sel2[%0d] got=%0d exp=%0d", i, sel_src2, m_sel(exp.two_src, exp.src2)); end
      step();
      checks++; if (obs !== exp) begin failures++; $display("FAIL rnd_state[%0d] got=%h exp=%h", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_forwarding();
    test_load_use();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC and operand fields.
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports id_pc, id_val_rn, id_val_rm  input  DATA_W  decoded PC and register-file operands.
REQ-005 SHALL have ports id_src1, id_src2, id_dest  input  4  source and destination register numbers.
REQ-006 SHALL have ports id_exe_cmd  input  4  ALU command; id_shift_op  input  12  shifter operand.
REQ-007 SHALL have 1-bit inputs id_valid, id_two_src, id_imm, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s: ID-stage qualifiers and controls.
REQ-008 SHALL have inputs freeze, flush, forward_en  1  external stall, branch-taken squash, forwarding enable.
REQ-009 SHALL have inputs mem_dest, wb_dest  4 and mem_wb_en, wb_wb_en  1  destinations and write enables of the MEM and WB stages.
REQ-010 SHALL have outputs ex_* (one per id_* input, same width) plus ex_valid  registered EX-stage fields.
REQ-011 SHALL have outputs sel_src1, sel_src2  2  select codes driving the EX-stage 3-input operand muxes.
REQ-012 SHALL have output hazard  1  load-use/no-forward stall request to IF/ID.

Function
REQ-013 SHALL update registered state only on rising clk; priority rst_n low > flush > freeze > hazard bubble > load.
REQ-014 SHALL, on flush=1, clear every ex_* output and ex_valid to 0 at the next edge, regardless of freeze or hazard.
REQ-015 SHALL, on freeze=1 (no flush), hold every ex_* output and ex_valid unchanged.
REQ-016 SHALL, on hazard=1 (no flush/freeze), insert a bubble: ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s cleared; data fields don't-care but driven to 0.
REQ-017 SHALL otherwise capture all id_* fields with one-cycle latency, ex_valid <= id_valid.
REQ-018 SHALL compute hazard combinationally: id_valid & ex_valid & ex_mem_r_en & src match, where src match = (id_src1==ex_dest) | (id_two_src & id_src2==ex_dest).
REQ-019 SHALL, when forward_en=0, additionally assert hazard on src match against ex_dest (ex_valid & ex_wb_en) or mem_dest (mem_wb_en).
REQ-020 SHALL compute sel_src1 combinationally from ex_src1: 2'd1 if forward_en & mem_wb_en & mem_dest==ex_src1; else 2'd2 if forward_en & wb_wb_en & wb_dest==ex_src1; else 2'd0.
REQ-021 SHALL compute sel_src2 identically from ex_src2, additionally forced to 2'd0 when ex_two_src=0.
REQ-022 SHALL give MEM-stage match priority over WB-stage match when both hit.
REQ-023 SHALL force sel_src1/sel_src2 to 2'd0 and hazard to 0 whenever ex_valid=0 (for sel) or id_valid=0 (for hazard); never code 2'd3.
REQ-024 SHALL not gate hazard with freeze or flush; consumer ignores it during flush.

Reset
REQ-025 SHALL, while rst_n=0 at a rising edge, clear every ex_* output and ex_valid to 0; sel_src1/sel_src2 then read 2'd0 and hazard reads 0.
REQ-026 SHALL give reset priority over flush, freeze and hazard; a reset mid-stall leaves no bubble or held state.
REQ-027 SHALL resume normal capture on the first edge after rst_n returns high.

Verification
REQ-028 Load path: id_valid=1, id_pc=0x10, id_dest=3, id_wb_en=1 -> next cycle ex_pc=0x10, ex_dest=3, ex_wb_en=1, ex_valid=1.
REQ-029 Forwarding: ex_src1=5, mem_dest=5, mem_wb_en=1, wb_dest=5, wb_wb_en=1, forward_en=1 -> sel_src1=1; drop mem_wb_en -> sel_src1=2; forward_en=0 -> 0.
REQ-030 Load-use: ex_mem_r_en=1, ex_dest=4, ex_valid=1, id_src2=4, id_two_src=1 -> hazard=1, next cycle ex_valid=0, ex_wb_en=0 (bubble); with id_two_src=0 -> hazard=0.
REQ-031 Priority: flush=1 with freeze=1 and hazard=1 -> next cycle all ex_* = 0; freeze=1 alone -> ex_pc holds 0x10 across 3 edges.
REQ-032 Reset mid-operation: rst_n=0 for one edge while ex_wb_en=1, ex_dest=7 -> all ex_* = 0, sel_src1=sel_src2=0, hazard=0; next edge captures id_* normally.
